// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared state encoding and default opcode constants for the multicycle control unit
package cu_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        FETCH     = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    localparam logic [5:0] DEF_RTYPE_OPCODE = 6'b000000;
    localparam logic [5:0] DEF_ITYPE_OPCODE = 6'b111111;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - instruction-memory valid/ready handshake bundle
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6
);
    logic                instr_valid;
    logic                instr_ready;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  function_code;

    modport master (output instr_valid, output opcode, output function_code, input instr_ready);
    modport slave  (input instr_valid, input opcode, input function_code, output instr_ready);
endinterface

// File: rtl/cu_decoder.sv
// rtl/cu_decoder.sv - combinational classification of the latched opcode/function code
module cu_decoder #(
    parameter int                  OPCODE_W     = 6,
    parameter int                  FUNCT_W      = 6,
    parameter logic [OPCODE_W-1:0] RTYPE_OPCODE = {OPCODE_W{1'b0}},
    parameter logic [OPCODE_W-1:0] ITYPE_OPCODE = {OPCODE_W{1'b1}}
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    output logic                is_rtype_o,
    output logic                is_itype_o,
    output logic                is_illegal_o,
    output logic                alu_src_o,
    output logic                alu_to_reg_o
);
    // Only the function-code MSB matters here; the ALU consumes the rest.
    logic unused_funct_bits;
    assign unused_funct_bits = ^funct_i[FUNCT_W-2:0];

    assign is_rtype_o   = (opcode_i == RTYPE_OPCODE);
    assign is_itype_o   = (opcode_i == ITYPE_OPCODE);
    assign is_illegal_o = !is_rtype_o && !is_itype_o;
    assign alu_src_o    = funct_i[FUNCT_W-1];
    assign alu_to_reg_o = (opcode_i != ITYPE_OPCODE);
endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - FETCH/DECODE/EXECUTE/WRITEBACK sequencer; CU_RETIRE_COUNT_EN adds retired_count
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int                  OPCODE_W     = 6,
    parameter int                  FUNCT_W      = 6,
    parameter logic [OPCODE_W-1:0] RTYPE_OPCODE = {OPCODE_W{1'b0}},
    parameter logic [OPCODE_W-1:0] ITYPE_OPCODE = {OPCODE_W{1'b1}},
    parameter int                  EXEC_TIMEOUT = 16
`ifdef CU_RETIRE_COUNT_EN
    ,
    parameter int                  CNT_W        = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_control_unit_if.slave bus,
    input  logic                  alu_done,
    output logic                  ir_write,
    output logic                  alu_start,
    output logic                  ALUSrc,
    output logic                  ALUtoReg,
    output logic                  reg_write,
    output logic                  pc_write,
    output logic                  illegal_instr,
    output logic                  exec_timeout,
    output logic [STATE_W-1:0]    state_dbg
`ifdef CU_RETIRE_COUNT_EN
    ,
    output logic [CNT_W-1:0]      retired_count
`endif
);
    localparam int                WAIT_W   = $clog2(EXEC_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(EXEC_TIMEOUT);

    state_t                state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [OPCODE_W-1:0]   opcode_q;
    logic [FUNCT_W-1:0]    funct_q;
    logic                  ir_load;
    logic                  is_rtype, is_itype, is_illegal, alu_src, alu_to_reg;

    cu_decoder #(
        .OPCODE_W    (OPCODE_W),
        .FUNCT_W     (FUNCT_W),
        .RTYPE_OPCODE(RTYPE_OPCODE),
        .ITYPE_OPCODE(ITYPE_OPCODE)
    ) u_decoder (
        .opcode_i    (opcode_q),
        .funct_i     (funct_q),
        .is_rtype_o  (is_rtype),
        .is_itype_o  (is_itype),
        .is_illegal_o(is_illegal),
        .alu_src_o   (alu_src),
        .alu_to_reg_o(alu_to_reg)
    );

    assign bus.instr_ready = (state_q == FETCH);
    assign ir_write        = ir_load;
    assign state_dbg       = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            wait_q   <= '0;
            opcode_q <= '0;
            funct_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (ir_load) begin
                opcode_q <= bus.opcode;
                funct_q  <= bus.function_code;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        ir_load       = 1'b0;
        alu_start     = 1'b0;
        reg_write     = 1'b0;
        pc_write      = 1'b0;
        illegal_instr = 1'b0;
        exec_timeout  = 1'b0;
        ALUSrc        = 1'b0;
        ALUtoReg      = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (bus.instr_valid) begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (is_illegal) begin
                    illegal_instr = 1'b1;
                    pc_write      = 1'b1;
                    state_d       = FETCH;
                end else if (is_rtype) begin
                    wait_d  = WAIT_ONE;
                    state_d = EXECUTE;
                end else if (is_itype) begin
                    state_d = WRITEBACK;
                end
            end
            EXECUTE: begin
                // The counter reads 1 only on the entry cycle, which marks alu_start.
                alu_start = (wait_q == WAIT_ONE);
                if (alu_src || alu_done) begin
                    state_d = WRITEBACK;
                end else if (wait_q == WAIT_MAX) begin
                    exec_timeout = 1'b1;
                    pc_write     = 1'b1;
                    state_d      = FETCH;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            WRITEBACK: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (state_q != FETCH) begin
            ALUSrc   = alu_src;
            ALUtoReg = alu_to_reg;
        end
    end

`ifdef CU_RETIRE_COUNT_EN
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (state_q == WRITEBACK) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign retired_count = retired_q;
`endif
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath control unit.
- Sequences each instruction through FETCH/DECODE/EXECUTE/WRITEBACK with a valid/ready handshake toward instruction memory.
- Waits on an iterative ALU for shift-amount operations, with a timeout, and flags illegal opcodes.
- Drives ALUSrc/ALUtoReg plus register-file, PC and IR write strobes for the multi-cycle datapath.

Parameters:
- OPCODE_W, 6: opcode field width.
- FUNCT_W, 6: function-code field width; MSB selects operand source.
- RTYPE_OPCODE, all zeros: R-type opcode value.
- ITYPE_OPCODE, all ones: I-type (load-immediate) opcode value.
- EXEC_TIMEOUT, 16: maximum EXECUTE wait cycles for alu_done (≥2).
- CNT_W, 16: width of the retired-instruction counter (optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  opcode/function_code valid from instruction memory.
- instr_ready  out  1  unit accepts an instruction (Moore, high in FETCH only).
- opcode  in  OPCODE_W  instruction opcode, sampled on handshake.
- function_code  in  FUNCT_W  function code, sampled on handshake.
- alu_done  in  1  iterative ALU finished; ignored outside EXECUTE.
- ir_write  out  1  one-cycle pulse on handshake.
- alu_start  out  1  one-cycle pulse on the first EXECUTE cycle.
- ALUSrc  out  1  1 = register operand, 0 = shamt; held from DECODE until return to FETCH.
- ALUtoReg  out  1  1 = ALU result, 0 = sign-extender; held as ALUSrc.
- reg_write  out  1  register-file write, high in WRITEBACK only.
- pc_write  out  1  PC advance, one-cycle pulse per instruction.
- illegal_instr  out  1  one-cycle pulse on illegal opcode.
- exec_timeout  out  1  one-cycle pulse when EXECUTE wait expires.
- state_dbg  out  2  current state encoding.

Behaviour:
- Reset (async, rst_n=0): state=FETCH. Captured opcode/funct=0. instr_ready=1 after release. All other outputs 0. Any in-flight instruction is abandoned, with no reg_write/pc_write.
- FETCH: instr_ready=1.
  - instr_valid&instr_ready → latch opcode/function_code, pulse ir_write, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: register ALUSrc=function_code[FUNCT_W-1], ALUtoReg=(opcode!=ITYPE_OPCODE).
  - RTYPE_OPCODE → EXECUTE.
  - ITYPE_OPCODE → WRITEBACK.
  - Otherwise → pulse illegal_instr and pc_write, go to FETCH.
- EXECUTE: alu_start on the entry cycle only.
  - ALUSrc=1 → WRITEBACK next cycle; alu_done is not required.
  - ALUSrc=0 → wait counter starts at 1 on the entry cycle. alu_done → WRITEBACK.
  - Counter reaching EXEC_TIMEOUT without alu_done → pulse exec_timeout and pc_write, go to FETCH, no reg_write.
  - alu_done in the same cycle the counter hits EXEC_TIMEOUT: done wins, no timeout.
- WRITEBACK: reg_write=1 and pc_write=1 for one cycle, then FETCH.
- Latency from handshake cycle to reg_write:
  - I-type: 2 cycles.
  - R register: 3 cycles.
  - R shamt: 3 + (done cycle − entry cycle).
- Throughput: a new handshake is possible the cycle after WRITEBACK. Back-to-back instr_valid is held off by instr_ready=0.
- Inputs opcode/function_code are don't-care outside the handshake cycle.
- state_dbg encoding: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3.

Optional Feature:
- CU_RETIRE_COUNT_EN defined:
  - Adds output retired_count [CNT_W-1:0], reset 0.
  - Increments on every WRITEBACK cycle and wraps modulo 2^CNT_W.
  - Illegal and timed-out instructions do not count.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package cu_pkg: state localparams (FETCH..WRITEBACK), default RTYPE/ITYPE opcode constants, state_dbg width.
- One sub-module, cu_decoder (combinational):
  - Inputs: latched opcode/funct.
  - Outputs: is_rtype, is_itype, is_illegal, alu_src, alu_to_reg.
- FSM and wait counter stay in the top module.

Test Plan:
- Reset mid-EXECUTE of a shamt op (funct=6'b000010, no alu_done) → all strobes 0 immediately, state_dbg=0, instr_ready=1 after release, no reg_write.
- I-type opcode=6'b111111 handshake at cycle N → ALUtoReg=0, reg_write and pc_write high at N+2, instr_ready high again at N+3.
- R-type opcode=0, funct=6'b100000 → ALUSrc=1, ALUtoReg=1, alu_start at N+2, reg_write at N+3, no alu_done needed.
- R-type funct=6'b000010, alu_done asserted 5 cycles after alu_start → reg_write the following cycle. Repeat with alu_done never asserted → exec_timeout pulse after 16 EXECUTE cycles, pc_write=1, reg_write=0.
- opcode=6'b010101 → illegal_instr and pc_write pulse at N+1, back in FETCH at N+2, no alu_start/reg_write. With CU_RETIRE_COUNT_EN, retired_count unchanged.
- CNT_W=4, CU_RETIRE_COUNT_EN, 17 back-to-back I-type instructions → retired_count wraps 15→0, ends at 1.
